// File: rtl/inst_encoder.sv
// Instruction-memory loader: packs field commands into 32-bit MIPS words and writes them sequentially.
// Define INST_ENC_JUMP_EN to accept class 5 (J); otherwise class 5 is treated as illegal.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_RUN   | session open, accepting commands
// S_WRITE | one-cycle imem write strobe of the registered word
// S_DONE  | session ended (last command or memory full), waiting for start
module inst_encoder #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_class,
   input  logic [4:0]        cmd_rs,
   input  logic [4:0]        cmd_rt,
   input  logic [4:0]        cmd_rd,
   input  logic [5:0]        cmd_funct,
   input  logic [25:0]       cmd_imm,
   input  logic              cmd_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;

   state_t      state, state_nx;
   logic        ready_q;
   logic        last_q;
   logic        hs;
   logic        legal;
   logic [31:0] enc;

   // Start has priority, so a command offered alongside it is never taken.
   assign cmd_ready = ready_q & ~start;
   assign hs        = (state == S_RUN) & cmd_valid & cmd_ready;

   always_comb begin
      enc   = '0;
      legal = 1'b1;
      case (cmd_class)
         3'd0: enc = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, cmd_funct};
         3'd1: enc = {6'b100011, cmd_rs, cmd_rt, cmd_imm[15:0]};
         3'd2: enc = {6'b101011, cmd_rs, cmd_rt, cmd_imm[15:0]};
         3'd3: enc = {6'b000100, cmd_rs, cmd_rt, cmd_imm[15:0]};
         3'd4: enc = {6'b001000, cmd_rs, cmd_rt, cmd_imm[15:0]};
`ifdef INST_ENC_JUMP_EN
         3'd5: enc = {6'b000010, cmd_imm};
`else
         3'd5: legal = 1'b0;
`endif
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (start) begin
         state_nx = S_RUN;
      end else begin
         case (state)
            S_IDLE:  state_nx = S_IDLE;
            S_RUN: begin
               if (hs) begin
                  if (legal)         state_nx = S_WRITE;
                  else if (cmd_last) state_nx = S_DONE;
               end
            end
            S_WRITE: begin
               if (last_q || (imem_addr == {ADDR_W{1'b1}})) state_nx = S_DONE;
               else                                         state_nx = S_RUN;
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Status and strobe are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         imem_we <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         ready_q <= (state_nx == S_RUN);
         imem_we <= (state_nx == S_WRITE);
         busy    <= (state_nx == S_RUN) || (state_nx == S_WRITE);
         done    <= (state_nx == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_addr  <= '0;
         imem_wdata <= '0;
         count      <= '0;
         err        <= 1'b0;
         last_q     <= 1'b0;
      end else if (start) begin
         imem_addr <= '0;
         count     <= '0;
         err       <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (hs && legal) begin
                  imem_wdata <= enc;
                  last_q     <= cmd_last;
               end else if (hs) begin
                  err <= 1'b1;
               end
            end
            S_WRITE: begin
               imem_addr <= imem_addr + ADDR_ONE;
               count     <= count + CNT_ONE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder (ADDR_W=2) against a queue-based session model.
// Build with or without INST_ENC_JUMP_EN; the model follows the same macro.
module tb_inst_encoder;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;
`ifdef INST_ENC_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_last = 1'b0;
   logic [2:0]    cmd_class = '0;
   logic [4:0]    cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
   logic [5:0]    cmd_funct = '0;
   logic [25:0]   cmd_imm = '0;
   logic          cmd_ready, imem_we, busy, done, err;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   count;

   int n_chk = 0;
   int n_fail = 0;
   int exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   int m_addr, m_count;
   bit m_err, m_done;

   inst_encoder #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_class(cmd_class),
      .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_funct(cmd_funct),
      .cmd_imm(cmd_imm), .cmd_last(cmd_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_legal(input int cls);
      return (cls <= 4) || (cls == 5 && JUMP_EN);
   endfunction

   function automatic logic [31:0] model_enc(input int cls, input int rs, input int rt,
                                             input int rd, input int funct, input int imm);
      logic [31:0] base;
      base = (32'(rs) << 21) | (32'(rt) << 16);
      case (cls)
         0: return base | (32'(rd) << 11) | 32'(funct);
         1: return (32'd35 << 26) | base | (32'(imm) & 32'hFFFF);
         2: return (32'd43 << 26) | base | (32'(imm) & 32'hFFFF);
         3: return (32'd4 << 26) | base | (32'(imm) & 32'hFFFF);
         4: return (32'd8 << 26) | base | (32'(imm) & 32'hFFFF);
         default: return (32'd2 << 26) | (32'(imm) & 32'h03FF_FFFF);
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         if (exp_data_q.size() == 0) begin
            chk("spurious_write", 32'd1, 32'd0);
         end else begin
            chk("write_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
            chk("write_data", imem_wdata, exp_data_q.pop_front());
         end
      end
   end

   task automatic start_session();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      m_addr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0;
   endtask

   task automatic send_cmd(input int cls, input int rs, input int rt, input int rd,
                           input int funct, input int imm, input bit last);
      bit got;
      @(posedge clk); #1;
      cmd_class = 3'(cls); cmd_rs = 5'(rs); cmd_rt = 5'(rt); cmd_rd = 5'(rd);
      cmd_funct = 6'(funct); cmd_imm = 26'(imm); cmd_last = last; cmd_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cmd_ready) begin got = 1'b1; break; end
      end
      if (!got) begin
         chk("handshake_timeout", 32'd0, 32'd1);
      end else if (model_legal(cls)) begin
         exp_addr_q.push_back(m_addr);
         exp_data_q.push_back(model_enc(cls, rs, rt, rd, funct, imm));
         if (last || m_addr == DEPTH - 1) m_done = 1'b1;
         m_addr = (m_addr + 1) % DEPTH;
         m_count++;
      end else begin
         m_err = 1'b1;
         if (last) m_done = 1'b1;
      end
      @(posedge clk); #1 cmd_valid = 1'b0; cmd_last = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      chk({tag, "_done"}, 32'(got), 32'd1);
      chk({tag, "_count"}, 32'(count), 32'(m_count));
      chk({tag, "_err"}, 32'(err), 32'(m_err));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_pending"}, 32'(exp_data_q.size()), 32'd0);
   endtask

   initial begin
      bit seen;
      int n;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      rst_n = 1'b1;

      start_session();
      send_cmd(1, 1, 2, 0, 0, 'h0004, 1'b0);
      send_cmd(0, 1, 2, 3, 'h20, 0, 1'b1);
      wait_done("lw_add");

      start_session();
      send_cmd(3, 1, 2, 0, 0, 'hFFFF, 1'b0);
      send_cmd(4, 0, 8, 0, 0, 5, 1'b0);
      send_cmd(5, 0, 0, 0, 0, 'h10, 1'b1);
      wait_done("beq_addi_j");

      start_session();
      send_cmd(7, 3, 3, 3, 3, 3, 1'b0);
      send_cmd(2, 0, 4, 0, 0, 8, 1'b1);
      wait_done("illegal_sw");

      // start together with a valid command in RUN
      start_session();
      send_cmd(4, 1, 1, 0, 0, 1, 1'b0);
      @(posedge clk); #1;
      cmd_class = 3'd1; cmd_valid = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("start_blocks_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1 start = 1'b0; cmd_valid = 1'b0;
      m_addr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0;
      @(negedge clk);
      chk("start_clears_count", 32'(count), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
      send_cmd(0, 4, 5, 6, 'h22, 0, 1'b1);
      wait_done("restart");

      // fill memory without a last flag
      start_session();
      for (int i = 0; i < DEPTH; i++)
         send_cmd($urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 63), int'($urandom & 32'hFFFF), 1'b0);
      wait_done("full");
      @(posedge clk); #1 cmd_valid = 1'b1; cmd_class = 3'd1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (cmd_ready) seen = 1'b1;
      end
      chk("full_no_accept", 32'(seen), 32'd0);
      cmd_valid = 1'b0;

      // reset during a write
      start_session();
      send_cmd(1, 2, 3, 0, 0, 7, 1'b0);
      chk("we_before_reset", 32'(imem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_we_drop", 32'(imem_we), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_addr", 32'(imem_addr), 32'd0);
      chk("async_wdata", imem_wdata, 32'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;

      for (int s = 0; s < 8; s++) begin
         start_session();
         n = 0;
         while (!m_done) begin
            n++;
            send_cmd($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 63), int'($urandom & 32'h03FF_FFFF),
                     (n >= 8) || ($urandom_range(0, 4) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
         end
         wait_done("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction-memory loader that packs decoded-style field commands (class, rs, rt, rd, funct, immediate) into 32-bit MIPS words and writes them sequentially into instruction memory. It is the encoding counterpart of the main control decoder and supports its instruction set: R-type, LW, SW, BEQ, ADDI and J. It sits between the bench/boot-loader command source and the instruction-memory write port, and fills memory before the CPU is released.

## Interface

**Parameters**
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.

**Ports**

Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.

Session control:
- `start`  in  1  begin a new load session.

Command handshake:
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_class`  in  3  instruction class: 0 R-type, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J; 6–7 are illegal.

Command fields:
- `cmd_rs`, `cmd_rt`, `cmd_rd`  in  5 each  register fields.
- `cmd_funct`  in  6  R-type function field.
- `cmd_imm`  in  26  immediate. Bits [15:0] are used by I-type; bits [25:0] are used by J.
- `cmd_last`  in  1  final command of the session.

Instruction-memory write port:
- `imem_we`  out  1  one-cycle write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.

Status:
- `busy`  out  1  session in progress.
- `done`  out  1  session finished; held until the next `start`.
- `err`  out  1  sticky: an illegal class was received in this session.
- `count`  out  ADDR_W+1  number of words written in this session.

## Operation

**Encodings** (shamt is always 0)
- R-type: {000000, rs, rt, rd, 00000, funct}
- LW: {100011, rs, rt, imm[15:0]}
- SW: {101011, rs, rt, imm[15:0]}
- BEQ: {000100, rs, rt, imm[15:0]}
- ADDI: {001000, rs, rt, imm[15:0]}
- J: {000010, imm[25:0]}

**State machine:** IDLE, RUN, WRITE, DONE.
- IDLE:
  - `cmd_ready`=0.
  - On `start` → RUN; clear the address, `count` and `err`.
- RUN:
  - `cmd_ready`=1 and `busy`=1.
  - On a legal handshake: register the encoded word, current address and `cmd_last` → WRITE.
  - On an illegal class: no write and `err`←1. Go to DONE if `cmd_last`, else stay in RUN.
- WRITE:
  - `imem_we`=1 for exactly one cycle; `cmd_ready`=0.
  - Next cycle: `imem_addr`+1 and `count`+1.
  - Go to DONE if the registered last flag is set, or if the written address was 2^ADDR_W−1 (memory full). Otherwise go to RUN.
- DONE:
  - `done`=1 and `busy`=0.
  - On `start` → RUN with a cleared session.

**Boundary conditions**
- `start` in any state restarts the session and has priority.
- `cmd_ready` is forced to 0 in any cycle where `start`=1, so a simultaneous `start` and command is never accepted.
- After a full-memory stop, `count`=2^ADDR_W. The address wraps to 0 internally but no further write occurs.
- Commands offered in IDLE, WRITE or DONE are not accepted; the source must hold them.
- `rst_n` low mid-session aborts immediately. A write strobe in flight is dropped.

## Timing

- All outputs are registered.
- Reset values: state IDLE; `cmd_ready`, `imem_we`, `busy`, `done`, `err` = 0; `imem_addr`, `imem_wdata`, `count` = 0.
- Handshake at cycle N → `imem_we`=1 with valid address and data at cycle N+1.
- `count` updates at N+2.
- Maximum throughput is one word per 2 cycles.
- `done` asserts the cycle after the final WRITE cycle (or after the illegal last command).
- `start` takes effect the next cycle.

## Configuration

- `INST_ENC_JUMP_EN` defined: class 5 encodes J as specified.
- `INST_ENC_JUMP_EN` undefined: class 5 is illegal. No write occurs, `err` is set, and there is no J encoding logic.

## Test plan

- Reset with `rst_n` low mid-WRITE → all outputs 0; `imem_we` drops asynchronously.
- `start`, then LW (rs=1, rt=2, imm=0x0004) followed by R-type add (rs=1, rt=2, rd=3, funct=0x20, last) → writes 0x8C220004 at address 0 and 0x00221820 at address 1; `count`=2, `done`=1, `err`=0.
- BEQ (rs=1, rt=2, imm=0xFFFF), ADDI (rs=0, rt=8, imm=5), J (imm=0x10, last) → 0x1022FFFF, 0x20080005, 0x08000010. Without the macro, the J command writes nothing and sets `err`=1.
- Class 7 mid-session, then SW (rs=0, rt=4, imm=8, last) → one write of 0xAC040008 at address 0; `err`=1.
- With ADDR_W=2, 5 commands and no last → 4 writes at addresses 0–3; `done` after the 4th; `count`=4; the 5th command is not accepted.
- `start` asserted together with `cmd_valid` in RUN → no handshake; `count` is cleared to 0.
